ara_rst_seq: RTL and testbench

ARA_RST_SEQ -- requirements
Module: ara_rst_seq

---
 rtl/ara_rst_seq.sv | 176 +++++++++++++++++
 tb/tb_ara_rst_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ara_rst_seq.sv
// ara_rst_seq: board reset sequencer for the CVA6+Ara SoC.
// Filters PLL lock, releases the fabric first and core/peripherals after a
// hold period, honours debug-module ndmreset, and records the reset cause.
module ara_rst_seq #(
  parameter int unsigned LockFilterCycles = 1024,
  parameter int unsigned HoldCycles       = 16,
  parameter int unsigned NdmHoldCycles    = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pll_locked_i,
  input  logic       ndmreset_i,
  output logic       fabric_rst_no,
  output logic       core_rst_no,
  output logic       periph_rst_no,
  output logic [2:0] state_o,
  output logic [1:0] rst_cause_o,
  output logic [7:0] lock_loss_cnt_o
);

  typedef enum logic [2:0] {
    ST_RESET       = 3'd0,
    ST_WAIT_LOCK   = 3'd1,
    ST_FABRIC_HOLD = 3'd2,
    ST_RUN         = 3'd3,
    ST_NDM_HOLD    = 3'd4
  } state_e;

  localparam logic [15:0] LockTarget = LockFilterCycles[15:0];
  localparam logic [15:0] HoldTarget = HoldCycles[15:0];
  localparam logic [15:0] NdmTarget  = NdmHoldCycles[15:0];

  localparam logic [1:0] CauseLockLoss = 2'b01;
  localparam logic [1:0] CauseNdm      = 2'b10;

  state_e      state_q, state_d;
  logic [1:0]  sync_q, sync_d;
  logic [15:0] cnt_q, cnt_d;
  logic        fabric_q, fabric_d;
  logic        core_q, core_d;
  logic        periph_q, periph_d;
  logic [1:0]  cause_q, cause_d;
  logic [7:0]  loss_cnt_q, loss_cnt_d;

  logic        lock_s;
  logic [15:0] cnt_inc;
  logic        lock_loss;

  assign lock_s  = sync_q[1];
  assign cnt_inc = cnt_q + 16'd1;

  // Register stage: synchronizer, FSM state, phase counter and all outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_RESET;
      sync_q     <= 2'b00;
      cnt_q      <= 16'd0;
      fabric_q   <= 1'b0;
      core_q     <= 1'b0;
      periph_q   <= 1'b0;
      cause_q    <= 2'b00;
      loss_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      fabric_q   <= fabric_d;
      core_q     <= core_d;
      periph_q   <= periph_d;
      cause_q    <= cause_d;
      loss_cnt_q <= loss_cnt_d;
    end
  end

  // Next-state logic. The synchronizer stays cleared in RESET, so the
  // filter latency always counts from WAIT_LOCK entry. A lock loss
  // overrides any ndmreset decision made in the same cycle.
  always_comb begin
    state_d    = state_q;
    sync_d     = (state_q == ST_RESET) ? 2'b00 : {sync_q[0], pll_locked_i};
    cnt_d      = cnt_q;
    fabric_d   = fabric_q;
    core_d     = core_q;
    periph_d   = periph_q;
    cause_d    = cause_q;
    loss_cnt_d = loss_cnt_q;
    lock_loss  = 1'b0;

    case (state_q)
      ST_RESET: begin
        state_d  = ST_WAIT_LOCK;
        cnt_d    = 16'd0;
        fabric_d = 1'b0;
        core_d   = 1'b0;
        periph_d = 1'b0;
      end
      ST_WAIT_LOCK: begin
        if (!lock_s) begin
          cnt_d = 16'd0;
        end else if (cnt_inc == LockTarget) begin
          state_d  = ST_FABRIC_HOLD;
          cnt_d    = 16'd0;
          fabric_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_FABRIC_HOLD: begin
        if (!lock_s) begin
          lock_loss = 1'b1;
        end else if (ndmreset_i) begin
          cnt_d = 16'd0;
        end else if (cnt_inc == HoldTarget) begin
          state_d  = ST_RUN;
          cnt_d    = 16'd0;
          core_d   = 1'b1;
          periph_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          lock_loss = 1'b1;
        end else if (ndmreset_i) begin
          state_d  = ST_NDM_HOLD;
          cnt_d    = 16'd0;
          core_d   = 1'b0;
          periph_d = 1'b0;
          cause_d  = CauseNdm;
        end
      end
      ST_NDM_HOLD: begin
        if (!lock_s) begin
          lock_loss = 1'b1;
        end else if (ndmreset_i) begin
          cnt_d = 16'd0;
        end else if (cnt_inc == NdmTarget) begin
          state_d  = ST_RUN;
          cnt_d    = 16'd0;
          core_d   = 1'b1;
          periph_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d  = ST_RESET;
        cnt_d    = 16'd0;
        fabric_d = 1'b0;
        core_d   = 1'b0;
        periph_d = 1'b0;
      end
    endcase

    if (lock_loss) begin
      state_d  = ST_WAIT_LOCK;
      cnt_d    = 16'd0;
      fabric_d = 1'b0;
      core_d   = 1'b0;
      periph_d = 1'b0;
      cause_d  = CauseLockLoss;
      if (loss_cnt_q != 8'hFF) begin
        loss_cnt_d = loss_cnt_q + 8'd1;
      end
    end
  end

  assign fabric_rst_no   = fabric_q;
  assign core_rst_no     = core_q;
  assign periph_rst_no   = periph_q;
  assign state_o         = state_q;
  assign rst_cause_o     = cause_q;
  assign lock_loss_cnt_o = loss_cnt_q;

endmodule

// File: tb/tb_ara_rst_seq.sv
// tb_ara_rst_seq: directed scenarios plus randomized stimulus for ara_rst_seq,
// compared every cycle against a phase-level behavioural model.
module tb_ara_rst_seq;

  localparam int LF = 4;
  localparam int HC = 3;
  localparam int NH = 2;

  logic       clk;
  logic       rstN;
  logic       pll;
  logic       ndm;
  logic       fabricN;
  logic       coreN;
  logic       periphN;
  logic [2:0] stateO;
  logic [1:0] causeO;
  logic [7:0] lossCntO;

  int testsRun    = 0;
  int testsFailed = 0;

  // Model: phase number as the state code, a run length for the active
  // phase, and a two-deep delay line standing in for the lock synchronizer.
  int mPhase;
  int mRun;
  int mCause;
  int mLossCnt;
  bit mS1;
  bit mS2;

  ara_rst_seq #(
    .LockFilterCycles(LF),
    .HoldCycles(HC),
    .NdmHoldCycles(NH)
  ) dut (
    .clk_i(clk),
    .rst_ni(rstN),
    .pll_locked_i(pll),
    .ndmreset_i(ndm),
    .fabric_rst_no(fabricN),
    .core_rst_no(coreN),
    .periph_rst_no(periphN),
    .state_o(stateO),
    .rst_cause_o(causeO),
    .lock_loss_cnt_o(lossCntO)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mPhase   = 0;
    mRun     = 0;
    mCause   = 0;
    mLossCnt = 0;
    mS1      = 1'b0;
    mS2      = 1'b0;
  endtask

  task automatic modelLockLoss();
    mPhase = 1;
    mRun   = 0;
    mCause = 1;
    if (mLossCnt < 255) mLossCnt++;
  endtask

  // One clock edge of the sequencer as seen from its requirements.
  task automatic modelStep(input bit pllIn, input bit ndmIn);
    bit lockS;
    lockS = mS2;
    if (mPhase == 0) begin
      mS1 = 1'b0;
      mS2 = 1'b0;
    end else begin
      mS2 = mS1;
      mS1 = pllIn;
    end
    if (mPhase == 0) begin
      mPhase = 1;
      mRun   = 0;
    end else if (mPhase == 1) begin
      mRun = lockS ? mRun + 1 : 0;
      if (mRun == LF) begin
        mPhase = 2;
        mRun   = 0;
      end
    end else if (!lockS) begin
      modelLockLoss();
    end else if (mPhase == 3) begin
      if (ndmIn) begin
        mPhase = 4;
        mRun   = 0;
        mCause = 2;
      end
    end else begin
      mRun = ndmIn ? 0 : mRun + 1;
      if (mRun == ((mPhase == 2) ? HC : NH)) begin
        mPhase = 3;
        mRun   = 0;
      end
    end
  endtask

  // Model advances on every clock edge and snaps to reset on rstN falling.
  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge rstN);
      if (!rstN) modelReset();
      else modelStep(pll, ndm);
    end
  end

  // Compare every output with the model on each falling clock edge.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("fabric", int'(fabricN), (mPhase >= 2) ? 1 : 0);
      checkOutput("core", int'(coreN), (mPhase == 3) ? 1 : 0);
      checkOutput("periph", int'(periphN), (mPhase == 3) ? 1 : 0);
      checkOutput("state", int'(stateO), mPhase);
      checkOutput("cause", int'(causeO), mCause);
      checkOutput("lossCnt", int'(lossCntO), mLossCnt);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input bit p, input bit nd);
    pll = p;
    ndm = nd;
  endtask

  task automatic powerUp(input string tag);
    applyStimulus(1'b1, 1'b0);
    rstN = 1'b0;
    tick(2);
    rstN = 1'b1;
    tick(6);
    checkOutput({tag, "_fabric_c6"}, int'(fabricN), 0);
    tick(1);
    checkOutput({tag, "_fabric_c7"}, int'(fabricN), 1);
    checkOutput({tag, "_state_c7"}, int'(stateO), 2);
    tick(2);
    checkOutput({tag, "_core_c9"}, int'(coreN), 0);
    tick(1);
    checkOutput({tag, "_core_c10"}, int'(coreN), 1);
    checkOutput({tag, "_periph_c10"}, int'(periphN), 1);
    checkOutput({tag, "_state_c10"}, int'(stateO), 3);
    checkOutput({tag, "_cause_c10"}, int'(causeO), 0);
  endtask

  // Directed scenarios followed by a randomized run.
  initial begin
    bit nextPll;
    bit nextNdm;
    rstN = 1'b0;
    applyStimulus(1'b1, 1'b0);

    powerUp("pu");

    // ndmreset pulse of five cycles while running
    applyStimulus(1'b1, 1'b1);
    tick(1);
    checkOutput("ndm_core_low", int'(coreN), 0);
    checkOutput("ndm_periph_low", int'(periphN), 0);
    checkOutput("ndm_fabric_high", int'(fabricN), 1);
    checkOutput("ndm_state", int'(stateO), 4);
    checkOutput("ndm_cause", int'(causeO), 2);
    tick(4);
    applyStimulus(1'b1, 1'b0);
    tick(1);
    checkOutput("ndm_core_still_low", int'(coreN), 0);
    tick(1);
    checkOutput("ndm_core_release", int'(coreN), 1);
    checkOutput("ndm_state_run", int'(stateO), 3);

    // lock loss while ndmreset is held
    applyStimulus(1'b1, 1'b1);
    tick(1);
    checkOutput("ll_state_ndm", int'(stateO), 4);
    applyStimulus(1'b0, 1'b1);
    tick(2);
    checkOutput("ll_state_sync_delay", int'(stateO), 4);
    tick(1);
    checkOutput("ll_state", int'(stateO), 1);
    checkOutput("ll_fabric", int'(fabricN), 0);
    checkOutput("ll_core", int'(coreN), 0);
    checkOutput("ll_periph", int'(periphN), 0);
    checkOutput("ll_cause", int'(causeO), 1);
    checkOutput("ll_cnt", int'(lossCntO), 1);

    // single-cycle lock glitch after three filter counts
    applyStimulus(1'b1, 1'b0);
    tick(3);
    applyStimulus(1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b0);
    tick(5);
    checkOutput("glitch_fabric_held", int'(fabricN), 0);
    checkOutput("glitch_state_wait", int'(stateO), 1);
    tick(1);
    checkOutput("glitch_fabric_release", int'(fabricN), 1);
    checkOutput("glitch_state_hold", int'(stateO), 2);

    // board reset in the middle of FABRIC_HOLD
    tick(1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("arst_fabric", int'(fabricN), 0);
    checkOutput("arst_core", int'(coreN), 0);
    checkOutput("arst_periph", int'(periphN), 0);
    checkOutput("arst_state", int'(stateO), 0);
    checkOutput("arst_cause", int'(causeO), 0);
    checkOutput("arst_cnt", int'(lossCntO), 0);
    powerUp("re");

    // repeated lock-loss events saturate the counter
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, 1'b0);
      tick(3);
      applyStimulus(1'b1, 1'b0);
      tick(8);
      if (i == 9) checkOutput("sat_cnt_10", int'(lossCntO), 10);
    end
    checkOutput("sat_cnt_255", int'(lossCntO), 255);

    // randomized lock, ndmreset and board-reset activity
    for (int c = 0; c < 2500; c++) begin
      nextPll = pll ? ($urandom_range(0, 63) != 0) : ($urandom_range(0, 3) == 0);
      nextNdm = ($urandom_range(0, 11) == 0) ? ~ndm : ndm;
      applyStimulus(nextPll, nextNdm);
      if ($urandom_range(0, 399) == 0) begin
        #2;
        rstN = 1'b0;
        tick(1);
        rstN = 1'b1;
      end else begin
        tick(1);
      end
    end

    tick(2);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
